free_list_allocator: RTL and testbench
======================================

FREE_LIST_ALLOCATOR -- requirements
Module: free_list_allocator

Interface
REQ-001 SHALL have parameter PHY_REGS, default 64, total physical registers; power of two.
REQ-002 SHALL have parameter ARCH_REGS, default 32, architectural registers; DEPTH = PHY_REGS-ARCH_REGS, power of two.
REQ-003 SHALL size all physical register tags with `PHY_REG_SEL from constants.vh, equal to log2(PHY_REGS).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 alloc_req_1 / alloc_req_2  input  1 each  rename slot 1/2 needs a new destination tag.
REQ-007 free_reg_1 / free_reg_2  output  `PHY_REG_SEL each  tags offered to the renaming logic as phy_dst_1/2_from_free_list.
REQ-008 alloc_stall  output  1  free list cannot satisfy this cycle's requests; rename group must hold.
REQ-009 commit_cnt  input  2  number of committing instructions (0..2) that allocated a tag.
REQ-010 rel_valid_1 / rel_valid_2  input  1 each  commit slot returns a stale tag.
REQ-011 rel_reg_1 / rel_reg_2  input  `PHY_REG_SEL each  stale tag being returned.
REQ-012 flush  input  1  misprediction/exception recovery; discard all speculative allocations.
REQ-013 free_count  output  log2(DEPTH)+1  number of tags currently free.
REQ-014 overflow_err  output  1  sticky error: release attempted while full, or commit_cnt exceeds allocated tags.

Function
REQ-015 SHALL store tags in a circular buffer of DEPTH entries with spec head, arch head, and tail pointers of log2(DEPTH) bits, wrapping naturally modulo DEPTH.
REQ-016 free_count SHALL equal DEPTH when tail==spec head and the buffer is full, else (tail-spec_head) mod DEPTH; a separate count register SHALL disambiguate full/empty.
REQ-017 req_n = alloc_req_1 + alloc_req_2; alloc_stall SHALL be combinational and equal (free_count < req_n) or flush.
REQ-018 Allocation SHALL be all-or-nothing: when alloc_stall=1 no tag is consumed and spec head holds.
REQ-019 free_reg_1 SHALL equal entry[spec_head]; free_reg_2 SHALL equal entry[spec_head+1] if alloc_req_1=1, else entry[spec_head] (packed allocation); both valid only when alloc_stall=0.
REQ-020 On a non-stalled cycle spec head SHALL advance by req_n (0, 1 or 2) at the next edge.
REQ-021 Releases SHALL be written at tail in slot order (slot 1 first, packed if only slot 2 valid); tail advances by rel_valid_1+rel_valid_2.
REQ-022 Releases SHALL NOT be bypassed to same-cycle allocation; alloc_stall uses the pre-edge free_count.
REQ-023 Same-cycle allocate and release SHALL both take effect; count_next = count - granted + released.
REQ-024 arch head SHALL advance by commit_cnt every cycle, including flush cycles.
REQ-025 On flush, spec head SHALL be loaded with arch_head+commit_cnt, allocation in that cycle SHALL be ignored, releases that cycle SHALL still be enqueued, and count SHALL be recomputed from the new pointers.
REQ-026 A release that would make count exceed DEPTH SHALL be dropped and set overflow_err; commit_cnt advancing arch head past spec head SHALL set overflow_err.
REQ-027 overflow_err SHALL clear only on reset.

Reset
REQ-028 On reset assertion, entry[i] SHALL become ARCH_REGS+i for i in 0..DEPTH-1, asynchronously.
REQ-029 On reset, spec head, arch head and tail SHALL be 0, count DEPTH, overflow_err 0.
REQ-030 Reset outputs: free_count=DEPTH, free_reg_1=ARCH_REGS, free_reg_2=ARCH_REGS+1 (when alloc_req_1=1), alloc_stall=0 unless flush.
REQ-031 Reset asserted mid-operation SHALL discard all pending allocations, releases and commits that cycle.

Verification
REQ-032 After reset, alloc_req_1=alloc_req_2=1 for one cycle -> free_reg_1=32, free_reg_2=33, alloc_stall=0; next cycle free_count=30, free_reg_1=34.
REQ-033 Only alloc_req_2=1 after reset -> free_reg_2=32, free_count becomes 31.
REQ-034 Drain to free_count=1, request both slots -> alloc_stall=1, free_count stays 1; request one slot -> granted, free_count=0.
REQ-035 free_count=0, both slots request while rel_valid_1/2 return tags 5 and 9 -> alloc_stall=1 that cycle; next cycle free_count=2, free_reg_1=5, free_reg_2=9.
REQ-036 Allocate 6 tags, commit_cnt=2 once, then flush -> spec head rewinds 4 entries, free_count=30, free_reg_1=34.
REQ-037 From reset (full), rel_valid_1=1 with tag 7 -> release dropped, free_count stays 32, overflow_err=1 until reset.

Source files
------------

// File: rtl/free_list_allocator_if.sv
// Free-list allocator bus: rename-side allocation, commit-side release and
// recovery signals bundled so the renamer and the allocator share one port.
// The physical tag width normally comes from constants.vh; the guarded default
// below keeps this file self-contained when that header is not on the path.
`ifndef PHY_REG_SEL
`define PHY_REG_SEL 6
`endif

interface free_list_allocator_if #(
   parameter int PHY_REGS  = 64,
   parameter int ARCH_REGS = 32
);
   localparam int TAG_W = `PHY_REG_SEL;
   localparam int CNT_W = $clog2(PHY_REGS - ARCH_REGS) + 1;

   logic             alloc_req_1;
   logic             alloc_req_2;
   logic [TAG_W-1:0] free_reg_1;
   logic [TAG_W-1:0] free_reg_2;
   logic             alloc_stall;
   logic [1:0]       commit_cnt;
   logic             rel_valid_1;
   logic             rel_valid_2;
   logic [TAG_W-1:0] rel_reg_1;
   logic [TAG_W-1:0] rel_reg_2;
   logic             flush;
   logic [CNT_W-1:0] free_count;
   logic             overflow_err;

   // Renaming / commit logic side.
   modport master (
      output alloc_req_1, alloc_req_2, commit_cnt,
      output rel_valid_1, rel_valid_2, rel_reg_1, rel_reg_2, flush,
      input  free_reg_1, free_reg_2, alloc_stall, free_count, overflow_err
   );

   // Allocator side.
   modport slave (
      input  alloc_req_1, alloc_req_2, commit_cnt,
      input  rel_valid_1, rel_valid_2, rel_reg_1, rel_reg_2, flush,
      output free_reg_1, free_reg_2, alloc_stall, free_count, overflow_err
   );
endinterface

// File: rtl/free_list_allocator.sv
// Physical register free list for a 2-wide renamer.
// Circular buffer of DEPTH tags: [spec_head, tail) holds free tags,
// [arch_head, spec_head) holds speculatively allocated tags that a flush
// hands back. Allocation is all-or-nothing; releases are not bypassed.
module free_list_allocator #(
   parameter int PHY_REGS  = 64,
   parameter int ARCH_REGS = 32
) (
   input logic                  clk,
   input logic                  reset,
   free_list_allocator_if.slave bus
);
   localparam int DEPTH = PHY_REGS - ARCH_REGS;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TAG_W = `PHY_REG_SEL;

   logic [DEPTH-1:0][TAG_W-1:0] w_entry;

   logic [PTR_W-1:0] r_spec_head;
   logic [PTR_W-1:0] r_arch_head;
   logic [PTR_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;      // free tags; disambiguates full from empty
   logic [CNT_W-1:0] r_spec_cnt;   // allocated but not yet committed
   logic             r_overflow_err;

   logic [CNT_W-1:0] w_req_n;
   logic             w_alloc_stall;
   logic [CNT_W-1:0] w_grant;
   logic [CNT_W-1:0] w_commit_req;
   logic             w_commit_err;
   logic [CNT_W-1:0] w_commit;
   logic [CNT_W-1:0] w_spec_left;
   logic [CNT_W-1:0] w_base;
   logic [CNT_W-1:0] w_space;
   logic             w_wr1_en;
   logic             w_wr2_en;
   logic             w_rel_drop;
   logic [CNT_W-1:0] w_rel_n;
   logic [PTR_W-1:0] w_wr1_idx;
   logic [PTR_W-1:0] w_wr2_idx;
   logic [PTR_W-1:0] w_spec_head_p1;
   logic [PTR_W-1:0] w_arch_head_next;
   logic [PTR_W-1:0] w_spec_head_next;
   logic [PTR_W-1:0] w_tail_next;
   logic [CNT_W-1:0] w_count_next;
   logic [CNT_W-1:0] w_spec_cnt_next;

   // Per-cycle allocation, commit, release and flush arithmetic.
   always_comb begin
      w_req_n       = CNT_W'(bus.alloc_req_1) + CNT_W'(bus.alloc_req_2);
      // Decided on the pre-edge count so same-cycle releases never feed allocation.
      w_alloc_stall = (r_count < w_req_n) | bus.flush;
      w_grant       = w_alloc_stall ? '0 : w_req_n;

      // Committing more than is outstanding is flagged and clamped so the
      // pointers stay coherent until the error is dealt with by a reset.
      w_commit_req  = CNT_W'(bus.commit_cnt);
      w_commit_err  = (w_commit_req > r_spec_cnt);
      w_commit      = w_commit_err ? r_spec_cnt : w_commit_req;
      w_spec_left   = r_spec_cnt - w_commit;

      // Free tags before releases: a flush returns the still-speculative tags.
      w_base        = bus.flush ? (r_count + w_spec_left) : (r_count - w_grant);
      w_space       = CNT_W'(DEPTH) - w_base;

      // Slot 1 first; slot 2 packs onto tail when slot 1 is idle.
      w_wr1_en      = bus.rel_valid_1 && (w_space != '0);
      w_wr2_en      = bus.rel_valid_2 && (w_space > CNT_W'(w_wr1_en));
      w_rel_drop    = (bus.rel_valid_1 && !w_wr1_en) || (bus.rel_valid_2 && !w_wr2_en);
      w_rel_n       = CNT_W'(w_wr1_en) + CNT_W'(w_wr2_en);
      w_wr1_idx     = r_tail;
      w_wr2_idx     = r_tail + PTR_W'(w_wr1_en);

      w_spec_head_p1   = r_spec_head + PTR_W'(1);
      w_arch_head_next = r_arch_head + PTR_W'(w_commit);
      w_spec_head_next = bus.flush ? w_arch_head_next : (r_spec_head + PTR_W'(w_grant));
      w_spec_cnt_next  = bus.flush ? '0 : (w_spec_left + w_grant);
      w_tail_next      = r_tail + PTR_W'(w_rel_n);
      w_count_next     = w_base + w_rel_n;
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_entry
         logic [TAG_W-1:0] r_tag;

         // Entry resets to its identity tag and accepts at most one release per cycle.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_tag <= TAG_W'(ARCH_REGS + gi);
            end else if (w_wr2_en && (w_wr2_idx == PTR_W'(gi))) begin
               r_tag <= bus.rel_reg_2;
            end else if (w_wr1_en && (w_wr1_idx == PTR_W'(gi))) begin
               r_tag <= bus.rel_reg_1;
            end
         end

         assign w_entry[gi] = r_tag;
      end
   endgenerate

   // Pointer, count and sticky-error state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_spec_head    <= '0;
         r_arch_head    <= '0;
         r_tail         <= '0;
         r_count        <= CNT_W'(DEPTH);
         r_spec_cnt     <= '0;
         r_overflow_err <= 1'b0;
      end else begin
         r_spec_head    <= w_spec_head_next;
         r_arch_head    <= w_arch_head_next;
         r_tail         <= w_tail_next;
         r_count        <= w_count_next;
         r_spec_cnt     <= w_spec_cnt_next;
         r_overflow_err <= r_overflow_err | w_rel_drop | w_commit_err;
      end
   end

   assign bus.free_reg_1   = w_entry[r_spec_head];
   assign bus.free_reg_2   = bus.alloc_req_1 ? w_entry[w_spec_head_p1] : w_entry[r_spec_head];
   assign bus.alloc_stall  = w_alloc_stall;
   assign bus.free_count   = r_count;
   assign bus.overflow_err = r_overflow_err;
endmodule

// File: tb/tb_free_list_allocator.sv
// Bench for free_list_allocator: reset values, a vector table from reset,
// hand-built corner sequences, and a random run against a queue model.
module tb_free_list_allocator;
   localparam int PHY_REGS  = 64;
   localparam int ARCH_REGS = 32;
   localparam int DEPTH     = PHY_REGS - ARCH_REGS;
   localparam int TAG_W     = 6;
   localparam int CNT_W     = $clog2(DEPTH) + 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_checks = 0;
   int   n_err = 0;

   free_list_allocator_if #(.PHY_REGS(PHY_REGS), .ARCH_REGS(ARCH_REGS)) bus ();

   free_list_allocator #(.PHY_REGS(PHY_REGS), .ARCH_REGS(ARCH_REGS)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model: ordered free tags and ordered speculative tags.
   int free_q[$];
   int spec_q[$];
   bit m_err;

   // Current stimulus, kept for the model.
   bit c_a1, c_a2, c_rv1, c_rv2, c_fl;
   int c_cc, c_rr1, c_rr2;

   typedef struct {
      bit a1; bit a2; int cc; bit rv1; bit rv2; int rr1; int rr2; bit fl;
      bit e_stall; int e_fr1; int e_fr2; int e_cnt; bit e_err;
   } vec_t;
   vec_t tbl[7];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic set_in(input bit a1, input bit a2, input int cc, input bit rv1,
                         input bit rv2, input int rr1, input int rr2, input bit fl);
      c_a1 = a1; c_a2 = a2; c_cc = cc; c_rv1 = rv1; c_rv2 = rv2;
      c_rr1 = rr1; c_rr2 = rr2; c_fl = fl;
      bus.alloc_req_1 = a1;
      bus.alloc_req_2 = a2;
      bus.commit_cnt  = 2'(cc);
      bus.rel_valid_1 = rv1;
      bus.rel_valid_2 = rv2;
      bus.rel_reg_1   = TAG_W'(rr1);
      bus.rel_reg_2   = TAG_W'(rr2);
      bus.flush       = fl;
   endtask

   task automatic idle();
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      free_q.delete();
      spec_q.delete();
      for (int i = 0; i < DEPTH; i++) free_q.push_back(ARCH_REGS + i);
      m_err = 0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   // One clock of the allocator's rules applied to the queues.
   task automatic model_step();
      int  req_n;
      bit  stall;
      int  c;
      req_n = int'(c_a1) + int'(c_a2);
      stall = c_fl || (free_q.size() < req_n);
      c = c_cc;
      if (c > spec_q.size()) begin
         m_err = 1;
         c = spec_q.size();
      end
      repeat (c) void'(spec_q.pop_front());
      if (!stall) repeat (req_n) spec_q.push_back(free_q.pop_front());
      if (c_fl) begin
         for (int i = spec_q.size() - 1; i >= 0; i--) free_q.push_front(spec_q[i]);
         spec_q.delete();
      end
      if (c_rv1) begin
         if (free_q.size() < DEPTH) free_q.push_back(c_rr1); else m_err = 1;
      end
      if (c_rv2) begin
         if (free_q.size() < DEPTH) free_q.push_back(c_rr2); else m_err = 1;
      end
   endtask

   task automatic compare_model(input int cyc);
      int exp_stall;
      exp_stall = (c_fl || (free_q.size() < int'(c_a1) + int'(c_a2))) ? 1 : 0;
      check("rnd_stall", int'(bus.alloc_stall), exp_stall);
      check("rnd_count", int'(bus.free_count), free_q.size());
      check("rnd_err", int'(bus.overflow_err), int'(m_err));
      if (free_q.size() >= 1) check("rnd_fr1", int'(bus.free_reg_1), free_q[0]);
      if (c_a1 && free_q.size() >= 2) check("rnd_fr2", int'(bus.free_reg_2), free_q[1]);
      if (!c_a1 && free_q.size() >= 1) check("rnd_fr2", int'(bus.free_reg_2), free_q[0]);
      $display("rnd %0d: req=%0d%0d cc=%0d rel=%0d%0d fl=%0d stall=%0d cnt=%0d fr1=%0d",
               cyc, c_a1, c_a2, c_cc, c_rv1, c_rv2, c_fl, bus.alloc_stall,
               bus.free_count, bus.free_reg_1);
   endtask

   initial begin
      idle();

      // Vector table from reset: expectations are pre-edge outputs.
      tbl[0] = '{1, 1, 0, 0, 0, 0, 0, 0,  0, 32, 33, 32, 0};
      tbl[1] = '{0, 1, 0, 0, 0, 0, 0, 0,  0, 34, 34, 30, 0};
      tbl[2] = '{0, 0, 2, 0, 0, 0, 0, 0,  0, 35, 35, 29, 0};
      tbl[3] = '{1, 0, 0, 0, 0, 0, 0, 1,  1, 35, 36, 29, 0};
      tbl[4] = '{1, 0, 0, 0, 0, 0, 0, 0,  0, 34, 35, 30, 0};
      tbl[5] = '{0, 0, 0, 0, 1, 0, 9, 0,  0, 35, 35, 29, 0};
      tbl[6] = '{0, 0, 0, 0, 0, 0, 0, 0,  0, 35, 35, 30, 0};

      // Reset state.
      do_reset();
      set_in(1, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("rst_count", int'(bus.free_count), DEPTH);
      check("rst_fr1", int'(bus.free_reg_1), ARCH_REGS);
      check("rst_fr2", int'(bus.free_reg_2), ARCH_REGS + 1);
      check("rst_stall", int'(bus.alloc_stall), 0);
      check("rst_err", int'(bus.overflow_err), 0);
      $display("reset: cnt=%0d fr1=%0d fr2=%0d", bus.free_count, bus.free_reg_1, bus.free_reg_2);

      // Table-driven sequence.
      do_reset();
      for (int i = 0; i < 7; i++) begin
         set_in(tbl[i].a1, tbl[i].a2, tbl[i].cc, tbl[i].rv1, tbl[i].rv2,
                tbl[i].rr1, tbl[i].rr2, tbl[i].fl);
         @(negedge clk);
         check($sformatf("tbl%0d_stall", i), int'(bus.alloc_stall), int'(tbl[i].e_stall));
         check($sformatf("tbl%0d_fr1", i), int'(bus.free_reg_1), tbl[i].e_fr1);
         check($sformatf("tbl%0d_fr2", i), int'(bus.free_reg_2), tbl[i].e_fr2);
         check($sformatf("tbl%0d_cnt", i), int'(bus.free_count), tbl[i].e_cnt);
         check($sformatf("tbl%0d_err", i), int'(bus.overflow_err), int'(tbl[i].e_err));
         $display("tbl %0d: stall=%0d fr1=%0d fr2=%0d cnt=%0d", i, bus.alloc_stall,
                  bus.free_reg_1, bus.free_reg_2, bus.free_count);
         tick();
      end

      // Drain to one free tag, then all-or-nothing, then release into empty list.
      do_reset();
      set_in(1, 1, 0, 0, 0, 0, 0, 0);
      repeat (15) tick();
      set_in(1, 0, 0, 0, 0, 0, 0, 0);
      tick();
      set_in(1, 1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("drain_stall2", int'(bus.alloc_stall), 1);
      check("drain_cnt1", int'(bus.free_count), 1);
      tick();
      set_in(1, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("drain_hold", int'(bus.free_count), 1);
      check("drain_stall1", int'(bus.alloc_stall), 0);
      check("drain_fr1", int'(bus.free_reg_1), 63);
      tick();
      set_in(1, 1, 0, 1, 1, 5, 9, 0);
      @(negedge clk);
      check("empty_cnt", int'(bus.free_count), 0);
      check("empty_stall", int'(bus.alloc_stall), 1);
      tick();
      set_in(1, 1, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("refill_cnt", int'(bus.free_count), 2);
      check("refill_fr1", int'(bus.free_reg_1), 5);
      check("refill_fr2", int'(bus.free_reg_2), 9);
      $display("drain: cnt=%0d fr1=%0d fr2=%0d", bus.free_count, bus.free_reg_1, bus.free_reg_2);
      idle();
      tick();

      // Allocate six, commit two, flush: four tags rewind.
      do_reset();
      set_in(1, 1, 0, 0, 0, 0, 0, 0);
      repeat (3) tick();
      set_in(0, 0, 2, 0, 0, 0, 0, 0);
      tick();
      set_in(0, 0, 0, 0, 0, 0, 0, 1);
      tick();
      idle();
      @(negedge clk);
      check("flush_cnt", int'(bus.free_count), 30);
      check("flush_fr1", int'(bus.free_reg_1), 34);
      $display("flush: cnt=%0d fr1=%0d", bus.free_count, bus.free_reg_1);

      // Release into a full list is dropped and sets a sticky error.
      do_reset();
      set_in(0, 0, 0, 1, 0, 7, 0, 0);
      tick();
      idle();
      @(negedge clk);
      check("ovf_cnt", int'(bus.free_count), 32);
      check("ovf_err", int'(bus.overflow_err), 1);
      check("ovf_fr1", int'(bus.free_reg_1), 32);
      repeat (5) tick();
      @(negedge clk);
      check("ovf_sticky", int'(bus.overflow_err), 1);
      do_reset();
      @(negedge clk);
      check("ovf_clear", int'(bus.overflow_err), 0);
      $display("overflow: err cleared=%0d", !bus.overflow_err);

      // Committing with nothing outstanding also flags the error.
      set_in(0, 0, 1, 0, 0, 0, 0, 0);
      tick();
      idle();
      @(negedge clk);
      check("commit_ovf_err", int'(bus.overflow_err), 1);
      $display("commit overflow: err=%0d", bus.overflow_err);

      // Random legal traffic against the queue model.
      do_reset();
      for (int cyc = 0; cyc < 1500; cyc++) begin
         bit a1, a2, rv1, rv2, fl;
         int cc, tot, mx;
         a1  = ($urandom_range(0, 9) < 7);
         a2  = ($urandom_range(0, 9) < 7);
         mx  = (spec_q.size() < 2) ? spec_q.size() : 2;
         cc  = $urandom_range(0, mx);
         fl  = ($urandom_range(0, 19) == 0);
         tot = free_q.size() + spec_q.size();
         rv1 = $urandom_range(0, 1) && (tot + 1 <= DEPTH);
         rv2 = $urandom_range(0, 1) && (tot + int'(rv1) + 1 <= DEPTH);
         set_in(a1, a2, cc, rv1, rv2, $urandom_range(0, PHY_REGS - 1),
                $urandom_range(0, PHY_REGS - 1), fl);
         @(negedge clk);
         compare_model(cyc);
         model_step();
         tick();
      end

      // Asynchronous reset mid-cycle: outputs return to reset values without a clock edge.
      idle();
      #2;
      reset = 1'b1;
      #1;
      check("async_cnt", int'(bus.free_count), DEPTH);
      check("async_fr1", int'(bus.free_reg_1), ARCH_REGS);
      check("async_err", int'(bus.overflow_err), 0);
      $display("async reset: cnt=%0d fr1=%0d", bus.free_count, bus.free_reg_1);
      @(posedge clk);
      #1;
      reset = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end
endmodule
